uart_rx_sampler: RTL and testbench

- Standalone 16x-oversampling UART receiver with a frame FIFO.
- Sits directly downstream of the UART tx pin and deserializes transmitted frames into words with per-frame error flags.
- Used as an independent checker of the UART transmitter in block- and chip-level benches, and as a synthesizable RX front end for a second UART instance.
- Line format is configured at runtime to match the transmitter's control registers.

---
 rtl/uart_rx_sampler.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// 16x-oversampling UART receiver: synchronizer, start/glitch detection, frame
// deserializer with parity/framing/break flags, and a frame FIFO with sticky overrun.
module uart_rx_sampler #(
  parameter int FAW         = 4,
  parameter int PW          = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           PCLK,
  input  logic           PRESET,
  input  logic           rx,
  input  logic           en,
  input  logic [PW-1:0]  prescale,
  input  logic [3:0]     data_size,
  input  logic [2:0]     parity,
  input  logic           stop2,
  output logic [8:0]     rd_data,
  output logic           rd_perr,
  output logic           rd_ferr,
  output logic           rd_brk,
  output logic           rd_valid,
  input  logic           rd_ready,
  output logic [FAW:0]   level,
  output logic           overrun,
  input  logic           overrun_clr,
  output logic           busy
);

  // state  | meaning
  // IDLE   | waiting for a falling edge on the synchronized line
  // START  | confirming the start bit at its centre (sc = 7)
  // DATA   | sampling data bits at bit centre (sc = 15)
  // PARITY | sampling and checking the parity bit
  // STOP1  | first stop bit; completes the frame unless two stops
  // STOP2  | second stop bit; completes the frame
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;

  localparam int DEPTH = 1 << FAW;
  localparam logic [FAW:0] LVL_FULL = (FAW+1)'(DEPTH);

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rxs_d;
  logic [PW-1:0]          r_pcnt;
  logic [3:0]             r_sc;
  logic [3:0]             r_bitcnt;
  logic [8:0]             r_data;
  logic                   r_par;
  logic                   r_any1;
  logic                   r_perr;
  logic                   r_ferr;
  logic [3:0]             r_dsz;
  logic [2:0]             r_pmode;
  logic                   r_stop2;

  logic       w_rxs, w_fall, w_tick, w_sample, w_start, w_push, w_par_exp;
  logic       w_ferr_fin, w_brk_fin;
  logic [3:0] w_dsz_in;
  logic [2:0] w_pmode_in;
  logic [11:0] w_word;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_sync  <= '1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], rx};
      r_rxs_d <= w_rxs;
    end
  end

  assign w_rxs    = r_sync[SYNC_STAGES-1];
  assign w_fall   = r_rxs_d & ~w_rxs;
  assign w_start  = (r_state == S_IDLE) & en & w_fall;
  assign w_tick   = (r_state != S_IDLE) && (r_pcnt == '0);
  assign w_sample = w_tick && (r_sc == 4'd15);

  // Held at prescale in IDLE so the first tick lands prescale+1 clocks after the edge.
  always_ff @(posedge PCLK) begin
    if (PRESET)
      r_pcnt <= '0;
    else if (r_state == S_IDLE || w_tick)
      r_pcnt <= prescale;
    else
      r_pcnt <= r_pcnt - PW'(1);
  end

  always_comb begin
    w_dsz_in = ((data_size >= 4'd5) && (data_size <= 4'd9)) ? data_size : 4'd8;
    case (parity)
      3'd1, 3'd2, 3'd4, 3'd5: w_pmode_in = parity;
      default:                w_pmode_in = 3'd0;
    endcase
    case (r_pmode)
      3'd1:    w_par_exp = ~r_par;
      3'd2:    w_par_exp = r_par;
      3'd5:    w_par_exp = 1'b1;
      default: w_par_exp = 1'b0;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE:   if (w_start) w_state_nxt = S_START;
      S_START:  if (w_tick && r_sc == 4'd7) w_state_nxt = w_rxs ? S_IDLE : S_DATA;
      S_DATA:   if (w_sample && r_bitcnt == r_dsz - 4'd1)
                  w_state_nxt = (r_pmode != 3'd0) ? S_PARITY : S_STOP1;
      S_PARITY: if (w_sample) w_state_nxt = S_STOP1;
      S_STOP1:  if (w_sample) begin
                  if (r_stop2) begin
                    w_state_nxt = S_STOP2;
                  end else begin
                    w_state_nxt = S_IDLE;
                    w_push      = 1'b1;
                  end
                end
      S_STOP2:  if (w_sample) begin
                  w_state_nxt = S_IDLE;
                  w_push      = 1'b1;
                end
      default:  w_state_nxt = S_IDLE;
    endcase
    if (!en) begin
      w_state_nxt = S_IDLE;
      w_push      = 1'b0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_sc     <= '0;
      r_bitcnt <= '0;
      r_data   <= '0;
      r_par    <= 1'b0;
      r_any1   <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_dsz    <= 4'd8;
      r_pmode  <= 3'd0;
      r_stop2  <= 1'b0;
    end else if (w_start) begin
      r_sc     <= '0;
      r_bitcnt <= '0;
      r_data   <= '0;
      r_par    <= 1'b0;
      r_any1   <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_dsz    <= w_dsz_in;
      r_pmode  <= w_pmode_in;
      r_stop2  <= stop2;
    end else if (w_tick) begin
      r_sc <= (r_state == S_START && r_sc == 4'd7) ? 4'd0 : r_sc + 4'd1;
      if (r_sc == 4'd15) begin
        case (r_state)
          S_DATA: begin
            r_data[r_bitcnt] <= w_rxs;
            r_par            <= r_par ^ w_rxs;
            r_any1           <= r_any1 | w_rxs;
            r_bitcnt         <= r_bitcnt + 4'd1;
          end
          S_PARITY: begin
            r_perr <= (w_rxs != w_par_exp);
            r_any1 <= r_any1 | w_rxs;
          end
          S_STOP1, S_STOP2: if (!w_rxs) r_ferr <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // The final stop sample is folded in combinationally so the push happens on it.
  assign w_ferr_fin = r_ferr | ~w_rxs;
  assign w_brk_fin  = w_ferr_fin & ~r_any1;
  assign w_word     = {w_brk_fin, w_ferr_fin, r_perr, r_data};

  logic [11:0]    r_mem [0:DEPTH-1];
  logic [FAW-1:0] r_wptr, r_rptr;
  logic [FAW:0]   r_level;
  logic           r_overrun;
  logic           w_full, w_pop, w_push_ok, w_ovf;
  logic [11:0]    w_head;

  assign w_full    = (r_level == LVL_FULL);
  assign w_pop     = rd_valid & rd_ready;
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_ovf     = w_push & w_full & ~w_pop;

  always_ff @(posedge PCLK) begin
    if (w_push_ok) r_mem[r_wptr] <= w_word;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + FAW'(1);
      if (w_pop)     r_rptr <= r_rptr + FAW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + (FAW+1)'(1);
        2'b01:   r_level <= r_level - (FAW+1)'(1);
        default: r_level <= r_level;
      endcase
      if (w_ovf)
        r_overrun <= 1'b1;
      else if (overrun_clr)
        r_overrun <= 1'b0;
    end
  end

  // Gated by valid so stale (never reset) memory never shows on the outputs.
  assign w_head   = r_mem[r_rptr];
  assign rd_valid = (r_level != '0);
  assign rd_data  = rd_valid ? w_head[8:0] : 9'd0;
  assign rd_perr  = rd_valid & w_head[9];
  assign rd_ferr  = rd_valid & w_head[10];
  assign rd_brk   = rd_valid & w_head[11];
  assign level    = r_level;
  assign overrun  = r_overrun;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: serial frames driven on rx, FIFO head
// and status compared against hand-computed values.
module tb_uart_rx_sampler;
  localparam int FAW = 2;
  localparam int PW  = 16;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          rx = 1'b1;
  logic          en = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic [3:0]    data_size = 4'd8;
  logic [2:0]    parity = 3'd0;
  logic          stop2 = 1'b0;
  logic [8:0]    rd_data;
  logic          rd_perr, rd_ferr, rd_brk, rd_valid;
  logic          rd_ready = 1'b0;
  logic [FAW:0]  level;
  logic          overrun;
  logic          overrun_clr = 1'b0;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int lat;

  uart_rx_sampler #(.FAW(FAW), .PW(PW), .SYNC_STAGES(2)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .rx(rx), .en(en), .prescale(prescale),
    .data_size(data_size), .parity(parity), .stop2(stop2),
    .rd_data(rd_data), .rd_perr(rd_perr), .rd_ferr(rd_ferr), .rd_brk(rd_brk),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .level(level), .overrun(overrun),
    .overrun_clr(overrun_clr), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  // start bit, nd data bits LSB first, optional parity (pbit < 0 = none), stop bits, one idle bit
  task automatic send_frame(input logic [8:0] d, input int nd, input int pbit,
                            input int nstop, input logic [1:0] sv);
    logic [15:0] seq;
    int n;
    int bt;
    bt = 16 * (int'(prescale) + 1);
    seq = '1;
    seq[0] = 1'b0;
    n = 1;
    for (int i = 0; i < nd; i++) begin seq[n] = d[i]; n++; end
    if (pbit >= 0) begin seq[n] = pbit[0]; n++; end
    for (int i = 0; i < nstop; i++) begin seq[n] = sv[i]; n++; end
    for (int i = 0; i < n; i++) begin
      @(negedge PCLK);
      rx = seq[i];
      repeat (bt - 1) @(negedge PCLK);
    end
    @(negedge PCLK);
    rx = 1'b1;
    repeat (bt - 1) @(negedge PCLK);
  endtask

  task automatic pop();
    @(negedge PCLK);
    rd_ready = 1'b1;
    @(negedge PCLK);
    rd_ready = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [8:0] d, input logic pe,
                            input logic fe, input logic bk);
    chk({tag, "_data"}, 32'(rd_data), 32'(d));
    chk({tag, "_perr"}, 32'(rd_perr), 32'(pe));
    chk({tag, "_ferr"}, 32'(rd_ferr), 32'(fe));
    chk({tag, "_brk"},  32'(rd_brk),  32'(bk));
  endtask

  initial begin
    cycles(3);
    chk("rst_data",    32'(rd_data), 32'h0);
    chk("rst_valid",   32'(rd_valid), 32'h0);
    chk("rst_level",   32'(level), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_busy",    32'(busy), 32'h0);
    PRESET = 1'b0;
    en = 1'b1;
    cycles(5);

    // 8N1, prescale 0; the start edge is the first negedge of the fork
    lat = -1;
    fork
      send_frame(9'h055, 8, -1, 1, 2'b11);
      begin
        for (int k = 1; k <= 400; k++) begin
          @(negedge PCLK);
          if (rd_valid && lat < 0) lat = k - 1;
        end
      end
    join
    chk("t1_lat_window", 32'((lat >= 150) && (lat <= 160)), 32'h1);
    chk("t1_level", 32'(level), 32'h1);
    check_head("t1", 9'h055, 1'b0, 1'b0, 1'b0);
    pop();
    chk("t1_empty", 32'(rd_valid), 32'h0);

    // 8E1, prescale 3: 0xA3 has four ones, so the even parity bit is 0
    prescale = 16'd3;
    parity = 3'd2;
    send_frame(9'h0A3, 8, 1, 1, 2'b11);
    check_head("t2_bad", 9'h0A3, 1'b1, 1'b0, 1'b0);
    pop();
    send_frame(9'h0A3, 8, 0, 1, 2'b11);
    check_head("t2_good", 9'h0A3, 1'b0, 1'b0, 1'b0);
    pop();

    // 9O2: nine ones, odd parity bit 0; second stop bit low
    prescale = 16'd0;
    data_size = 4'd9;
    parity = 3'd1;
    stop2 = 1'b1;
    send_frame(9'h1FF, 9, 0, 2, 2'b01);
    check_head("t3", 9'h1FF, 1'b0, 1'b1, 1'b0);
    pop();

    // break: line low for 20 bit times at 8N1
    data_size = 4'd8;
    parity = 3'd0;
    stop2 = 1'b0;
    @(negedge PCLK);
    rx = 1'b0;
    cycles(320);
    rx = 1'b1;
    cycles(40);
    chk("t4_brk_level", 32'(level), 32'h1);
    check_head("t4", 9'h000, 1'b0, 1'b1, 1'b1);
    pop();
    chk("t4_brk_popped", 32'(level), 32'h0);

    // 3-clock glitch is rejected at the start-bit centre
    @(negedge PCLK);
    rx = 1'b0;
    cycles(3);
    rx = 1'b1;
    chk("t4_glitch_busy", 32'(busy), 32'h1);
    cycles(30);
    chk("t4_glitch_idle", 32'(busy), 32'h0);
    chk("t4_glitch_level", 32'(level), 32'h0);

    // overrun with a 4-deep FIFO
    for (int i = 1; i <= 5; i++) send_frame(9'(i), 8, -1, 1, 2'b11);
    chk("t5_level", 32'(level), 32'h4);
    chk("t5_overrun", 32'(overrun), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      chk("t5_pop_data", 32'(rd_data), 32'(i));
      pop();
    end
    chk("t5_drained", 32'(level), 32'h0);
    chk("t5_ovr_sticky", 32'(overrun), 32'h1);
    @(negedge PCLK);
    overrun_clr = 1'b1;
    @(negedge PCLK);
    overrun_clr = 1'b0;
    chk("t5_ovr_clr", 32'(overrun), 32'h0);

    // en dropped during DATA discards the partial frame
    @(negedge PCLK);
    rx = 1'b0;
    cycles(16);
    rx = 1'b1;
    cycles(24);
    chk("t6_busy_data", 32'(busy), 32'h1);
    en = 1'b0;
    cycles(2);
    chk("t6_en_idle", 32'(busy), 32'h0);
    cycles(20);
    en = 1'b1;
    cycles(5);
    send_frame(9'h03C, 8, -1, 1, 2'b11);
    chk("t6_level", 32'(level), 32'h1);
    check_head("t6", 9'h03C, 1'b0, 1'b0, 1'b0);
    pop();

    // PRESET mid-frame flushes the FIFO
    send_frame(9'h011, 8, -1, 1, 2'b11);
    send_frame(9'h022, 8, -1, 1, 2'b11);
    chk("t7_queued", 32'(level), 32'h2);
    @(negedge PCLK);
    rx = 1'b0;
    cycles(16);
    rx = 1'b1;
    cycles(24);
    chk("t7_busy", 32'(busy), 32'h1);
    PRESET = 1'b1;
    cycles(1);
    PRESET = 1'b0;
    chk("t7_level", 32'(level), 32'h0);
    chk("t7_valid", 32'(rd_valid), 32'h0);
    chk("t7_busy_rst", 32'(busy), 32'h0);
    chk("t7_data", 32'(rd_data), 32'h0);
    cycles(5);
    send_frame(9'h05A, 8, -1, 1, 2'b11);
    chk("t7_after_level", 32'(level), 32'h1);
    chk("t7_after_data", 32'(rd_data), 32'h05A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
